// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy car controller.
// Latches floor request pulses into a pending register and sequences car
// motion and door timing. A single 32-bit down-counter times both a one-floor
// step and the door-open interval.
// Optional emergency stop: define ELEVATOR_ESTOP_EN to add the `estop` input.
//
// state | meaning
// IDLE  | car parked, doors closed, waiting for pending requests
// MOVE  | car travelling one floor per MOVE_CYCLES
// DOOR  | doors open for DOOR_CYCLES (reloaded by a same-floor request)
module elevator_scheduler #(
   parameter int FLOORS      = 4,
   parameter int MOVE_CYCLES = 100000000,
   parameter int DOOR_CYCLES = 200000000,
   localparam int FW         = $clog2(FLOORS)
) (
   input  logic              CLK,
   input  logic              reset_n,
`ifdef ELEVATOR_ESTOP_EN
   input  logic              estop,
`endif
   input  logic [FLOORS-1:0] req_pulse,
   output logic [FW-1:0]     cur_floor,
   output logic              dir_up,
   output logic              moving,
   output logic              door_open,
   output logic              arrive_pulse,
   output logic [FLOORS-1:0] pending
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_MOVE = 2'b01;
   localparam logic [1:0] S_DOOR = 2'b10;

   localparam logic [31:0] MOVE_LOAD = 32'(MOVE_CYCLES - 1);
   localparam logic [31:0] DOOR_LOAD = 32'(DOOR_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic              dir_q, dir_d;
   logic [FLOORS-1:0] pend_q, pend_d;
   logic              arrive_q, arrive_d;

   logic [FLOORS-1:0] pend_set;
   logic [FLOORS-1:0] clear_mask;
   logic [FW-1:0]     step_floor;

   // True when any request lies strictly beyond floor f in direction up.
   function automatic logic req_ahead(input logic [FLOORS-1:0] p,
                                      input logic [FW-1:0] f,
                                      input logic up);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
      end
      return r;
   endfunction

   // State and datapath registers.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         floor_q  <= '0;
         dir_q    <= 1'b1;
         pend_q   <= '0;
         arrive_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         arrive_q <= arrive_d;
      end
   end

   // Next state, counter, floor, direction and pending-request update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      arrive_d   = 1'b0;
      pend_set   = pend_q | req_pulse;
      clear_mask = '0;
      step_floor = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));

      case (state_q)
         S_IDLE: begin
            if (pend_q[floor_q]) begin
               state_d             = S_DOOR;
               cnt_d               = DOOR_LOAD;
               clear_mask[floor_q] = 1'b1;
            end else if (req_ahead(pend_q, floor_q, dir_q)) begin
               state_d = S_MOVE;
               cnt_d   = MOVE_LOAD;
            end else if (req_ahead(pend_q, floor_q, ~dir_q)) begin
               state_d = S_MOVE;
               cnt_d   = MOVE_LOAD;
               dir_d   = ~dir_q;
            end
         end
         S_MOVE: begin
            if (cnt_q != 32'd0) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               floor_d  = step_floor;
               arrive_d = 1'b1;
               if (pend_q[step_floor]) begin
                  state_d                = S_DOOR;
                  cnt_d                  = DOOR_LOAD;
                  clear_mask[step_floor] = 1'b1;
               end else if (req_ahead(pend_q, step_floor, dir_q)) begin
                  cnt_d = MOVE_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DOOR: begin
            // A call for the floor we are already serving just holds the door.
            pend_set[floor_q] = pend_q[floor_q];
            if (req_pulse[floor_q]) begin
               cnt_d = DOOR_LOAD;
            end else if (cnt_q != 32'd0) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pend_d = pend_set & ~clear_mask;

`ifdef ELEVATOR_ESTOP_EN
      if (estop) begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         floor_d  = floor_q;
         dir_d    = dir_q;
         arrive_d = 1'b0;
         pend_d   = pend_q | req_pulse;
      end
`endif
   end

   // Output decode from the registered state.
   always_comb begin
      moving       = (state_q == S_MOVE);
      door_open    = (state_q == S_DOOR);
      arrive_pulse = arrive_q;
`ifdef ELEVATOR_ESTOP_EN
      if (estop) arrive_pulse = 1'b0;
`endif
   end

   assign cur_floor = floor_q;
   assign dir_up    = dir_q;
   assign pending   = pend_q;

endmodule
